// File: rtl/ifmap_row_feeder_pkg.sv
// Shared types and constants for the IFMap row feeder: FSM state encoding,
// tag-bit positions of the tagged word and the skid-buffer depth.
package ifmap_feed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } feed_state_e;

    localparam int FEED_DATA_WIDTH  = 16;
    localparam int FEED_IFMAP_WIDTH = FEED_DATA_WIDTH + 2;
    localparam int TAG_FIRST_BIT    = FEED_IFMAP_WIDTH - 1;
    localparam int TAG_LAST_BIT     = FEED_IFMAP_WIDTH - 2;
    localparam int SKID_DEPTH       = 2;

    // Assemble a tagged word: first/last-of-row flags above the raw activation.
    function automatic logic [FEED_IFMAP_WIDTH-1:0] tag_word(
        input logic                       first,
        input logic                       last,
        input logic [FEED_DATA_WIDTH-1:0] data
    );
        logic [FEED_IFMAP_WIDTH-1:0] word;
        word                           = '0;
        word[TAG_FIRST_BIT]            = first;
        word[TAG_LAST_BIT]             = last;
        word[FEED_DATA_WIDTH-1:0]      = data;
        return word;
    endfunction

endpackage

// File: rtl/ifmap_row_feeder_if.sv
// Memory-read and FIFO-write bus of the IFMap row feeder; master is the feeder,
// slave is the memory/FIFO side.
interface ifmap_feed_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int IFMAP_WIDTH = 18,
    parameter int ADDR_WIDTH  = 10
);
    logic                   mem_ren;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   fifo_full;
    logic                   fifo_wen;
    logic [IFMAP_WIDTH-1:0] fifo_din;

    modport master (
        output mem_ren, mem_addr, fifo_wen, fifo_din,
        input  mem_rdata, fifo_full
    );

    modport slave (
        input  mem_ren, mem_addr, fifo_wen, fifo_din,
        output mem_rdata, fifo_full
    );
endinterface

// File: rtl/ifmap_row_feeder_skid_buffer.sv
// Two-entry skid FIFO between the memory read pipeline and the IFMap FIFO;
// push and pop may happen in the same cycle.
module ifmap_skid_buffer
    import ifmap_feed_pkg::*;
#(
    parameter int WIDTH = FEED_IFMAP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot_r [SKID_DEPTH];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;

    // Storage, pointers and occupancy; overflow is prevented by the issuer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                slot_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                slot_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = slot_r[rd_ptr_r];

endmodule

// File: rtl/ifmap_row_feeder.sv
// Streams an input feature map row by row from synchronous-read memory into the
// IFMap FIFO, tagging first/last words of each row, with a 2-entry skid buffer.
module ifmap_row_feeder
    import ifmap_feed_pkg::*;
#(
    parameter int DATA_WIDTH  = FEED_DATA_WIDTH,
    parameter int IFMAP_WIDTH = FEED_IFMAP_WIDTH,
    parameter int ADDR_WIDTH  = 10,
    parameter int LEN_WIDTH   = 8,
    parameter int ROWS_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [ROWS_WIDTH-1:0] num_rows,
    ifmap_feed_if.master          bus,
    output logic                  busy,
    output logic                  done
);

    feed_state_e           state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  col_r;
    logic [ROWS_WIDTH-1:0] rows_r;
    logic [ROWS_WIDTH-1:0] row_r;
    logic                  inflight_r;
    logic                  tag_first_r;
    logic                  tag_last_r;
    logic                  busy_r;
    logic                  done_r;

    logic [1:0]             skid_count_s;
    logic [IFMAP_WIDTH-1:0] skid_head_s;
    logic [2:0]             occ_s;
    logic                   wen_s;
    logic                   issue_s;
    logic                   last_col_s;
    logic                   last_row_s;
    logic                   drain_done_s;

    ifmap_skid_buffer #(.WIDTH(IFMAP_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (tag_word(tag_first_r, tag_last_r, bus.mem_rdata)),
        .pop       (wen_s),
        .count     (skid_count_s),
        .head      (skid_head_s)
    );

    // Issue decision: a read may go out only if its word is guaranteed a skid slot.
    always_comb begin
        wen_s        = (skid_count_s != 2'd0) && !bus.fifo_full;
        occ_s        = {1'b0, skid_count_s} + {2'b00, inflight_r};
        last_col_s   = (col_r == len_r - LEN_WIDTH'(1));
        last_row_s   = (row_r == rows_r - ROWS_WIDTH'(1));
        drain_done_s = !inflight_r &&
                       ((skid_count_s == 2'd0) || ((skid_count_s == 2'd1) && wen_s));
        if (state_r == FETCH) begin
            issue_s = (occ_s < (3'(SKID_DEPTH) + {2'b00, wen_s}));
        end else begin
            issue_s = 1'b0;
        end
    end

    // Control FSM with address/row/column counters and the in-flight tag pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            len_r       <= '0;
            col_r       <= '0;
            rows_r      <= '0;
            row_r       <= '0;
            inflight_r  <= 1'b0;
            tag_first_r <= 1'b0;
            tag_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_first_r <= (col_r == '0);
                tag_last_r  <= last_col_s;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_r <= base_addr;
                        len_r  <= row_len;
                        rows_r <= num_rows;
                        col_r  <= '0;
                        row_r  <= '0;
                        if ((row_len == '0) || (num_rows == '0)) begin
                            state_r <= FINISH;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FETCH;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue_s) begin
                        addr_r <= addr_r + ADDR_WIDTH'(1);
                        if (last_col_s) begin
                            col_r <= '0;
                            row_r <= row_r + ROWS_WIDTH'(1);
                            if (last_row_s) begin
                                state_r <= DRAIN;
                            end
                        end else begin
                            col_r <= col_r + LEN_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Finish as the last word leaves, so done follows the final write.
                    if (drain_done_s) begin
                        state_r <= FINISH;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_ren  = issue_s;
    assign bus.mem_addr = addr_r;
    assign bus.fifo_wen = wen_s;
    assign bus.fifo_din = skid_head_s;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_ifmap_row_feeder.sv
// Directed self-checking bench for ifmap_row_feeder: per-cycle capture of the
// DUT outputs after each start, then checks against hand-computed timelines.
module tb_ifmap_row_feeder;
    import ifmap_feed_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] base_addr;
    logic [7:0] row_len;
    logic [7:0] num_rows;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    ifmap_feed_if #(.DATA_WIDTH(16), .IFMAP_WIDTH(18), .ADDR_WIDTH(10)) bus ();

    ifmap_row_feeder #(
        .DATA_WIDTH(16), .IFMAP_WIDTH(18), .ADDR_WIDTH(10), .LEN_WIDTH(8), .ROWS_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address a holds 0x1000 + a; garbage when not read.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_ren ? (16'h1000 + {6'b000000, bus.mem_addr}) : 16'hDEAD;
    end

    logic        ren_a  [0:39];
    logic [9:0]  addr_a [0:39];
    logic        wen_a  [0:39];
    logic [17:0] din_a  [0:39];
    logic        busy_a [0:39];
    logic        done_a [0:39];
    logic [1:0]  st_a   [0:39];

    logic [1:0] tags3 [6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    logic [1:0] tags4 [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    logic [9:0] wrap_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    logic [17:0] wq [$];
    logic [9:0]  aq [$];
    int          cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a transfer (edge T) and record cycles T+1..T+ncyc.
    task automatic run(input logic [9:0] b, input logic [7:0] l, input logic [7:0] r,
                       input int ncyc, input int full_lo, input int full_hi,
                       input int rst_at, input int start_at);
        @(negedge clk);
        base_addr = b;
        row_len   = l;
        num_rows  = r;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wq.delete();
        aq.delete();
        for (int k = 1; k <= ncyc; k++) begin
            bus.fifo_full = (k >= full_lo) && (k <= full_hi);
            rst           = (k == rst_at) ? 1'b0 : 1'b1;
            start         = (k == start_at);
            @(negedge clk);
            ren_a[k]  = bus.mem_ren;
            addr_a[k] = bus.mem_addr;
            wen_a[k]  = bus.fifo_wen;
            din_a[k]  = bus.fifo_din;
            busy_a[k] = busy;
            done_a[k] = done;
            st_a[k]   = dut.state_r;
            if (bus.mem_ren) aq.push_back(bus.mem_addr);
            if (bus.fifo_wen) wq.push_back(bus.fifo_din);
            @(posedge clk);
            #1;
        end
        bus.fifo_full = 1'b0;
        rst           = 1'b1;
        start         = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = 10'h000; row_len = 8'd0; num_rows = 8'd0;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ren", bus.mem_ren, 1'b0);
        check("rst_addr", bus.mem_addr, 10'h000);
        check("rst_wen", bus.fifo_wen, 1'b0);
        check("rst_din", bus.fifo_din, 18'h00000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;

        // 1: base 0x010, 3 words x 2 rows, no backpressure.
        run(10'h010, 8'd3, 8'd2, 12, 99, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            check("t1_ren", ren_a[k], (k >= 1 && k <= 6));
            check("t1_wen", wen_a[k], (k >= 3 && k <= 8));
            check("t1_busy", busy_a[k], (k >= 1 && k <= 8));
            check("t1_done", done_a[k], (k == 9));
            if (k >= 1 && k <= 6) check("t1_addr", addr_a[k], 10'h010 + 10'(k - 1));
            if (k >= 3 && k <= 8) check("t1_din", din_a[k], {tags3[k-3], 16'h1010 + 16'(k - 3)});
        end

        // 2: single-word rows carry both tags.
        run(10'h020, 8'd1, 8'd3, 8, 99, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            check("t2_ren", ren_a[k], (k >= 1 && k <= 3));
            check("t2_wen", wen_a[k], (k >= 3 && k <= 5));
            check("t2_done", done_a[k], (k == 6));
            if (k >= 3 && k <= 5) check("t2_din", din_a[k], {2'b11, 16'h1020 + 16'(k - 3)});
        end

        // 3: fifo_full held through cycles 2..10.
        run(10'h100, 8'd4, 8'd1, 18, 2, 10, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            check("t3_ren", ren_a[k], (k == 1 || k == 2 || k == 11 || k == 12));
            check("t3_wen", wen_a[k], (k >= 11 && k <= 14));
            check("t3_busy", busy_a[k], (k >= 1 && k <= 14));
            check("t3_done", done_a[k], (k == 15));
            if (k >= 11 && k <= 14) check("t3_din", din_a[k], {tags4[k-11], 16'h1100 + 16'(k - 11)});
        end
        check("t3_nreads", aq.size(), 4);
        for (int j = 0; j < 4 && j < aq.size(); j++) check("t3_addr", aq[j], 10'h100 + 10'(j));

        // 4: zero row length, then zero row count.
        for (int z = 0; z < 2; z++) begin
            run(10'h000, (z == 0) ? 8'd0 : 8'd3, (z == 0) ? 8'd5 : 8'd0, 5, 99, 0, 0, 0);
            cnt = 0;
            for (int k = 1; k <= 5; k++) begin
                check("t4_ren", ren_a[k], 1'b0);
                check("t4_wen", wen_a[k], 1'b0);
                check("t4_busy", busy_a[k], 1'b0);
                if (done_a[k]) cnt++;
            end
            check("t4_done_cnt", cnt, 1);
            check("t4_done_early", (done_a[1] | done_a[2]), 1'b1);
        end

        // 5: address wraps modulo 2^10.
        run(10'h3FE, 8'd4, 8'd1, 10, 99, 0, 0, 0);
        check("t5_nreads", aq.size(), 4);
        check("t5_nwrites", wq.size(), 4);
        for (int j = 0; j < 4 && j < aq.size(); j++) check("t5_addr", aq[j], wrap_addr[j]);
        for (int j = 0; j < 4 && j < wq.size(); j++)
            check("t5_din", wq[j], {tags4[j], 16'h1000 + {6'b000000, wrap_addr[j]}});

        // 6: reset asserted in cycle 4 of a 2x3 transfer.
        run(10'h010, 8'd3, 8'd2, 14, 99, 0, 4, 0);
        check("t6_ren", ren_a[5], 1'b0);
        check("t6_addr", addr_a[5], 10'h000);
        check("t6_wen", wen_a[5], 1'b0);
        check("t6_din", din_a[5], 18'h00000);
        check("t6_busy", busy_a[5], 1'b0);
        check("t6_done", done_a[5], 1'b0);
        check("t6_state", st_a[5], IDLE);
        cnt = 0;
        for (int k = 5; k <= 14; k++) if (wen_a[k] || done_a[k] || busy_a[k]) cnt++;
        check("t6_quiet", cnt, 0);

        // 6b: clean restart after reset.
        run(10'h040, 8'd3, 8'd2, 12, 99, 0, 0, 0);
        check("t6b_nwrites", wq.size(), 6);
        for (int j = 0; j < 6 && j < wq.size(); j++) check("t6b_din", wq[j], {tags3[j], 16'h1040 + 16'(j)});
        check("t6b_done", done_a[9], 1'b1);

        // 7: start pulsed while busy is ignored.
        run(10'h010, 8'd3, 8'd2, 16, 99, 0, 0, 3);
        check("t7_nwrites", wq.size(), 6);
        check("t7_nreads", aq.size(), 6);
        cnt = 0;
        for (int k = 1; k <= 16; k++) if (done_a[k]) cnt++;
        check("t7_done_cnt", cnt, 1);
        check("t7_done", done_a[9], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
